// File: rtl/acc32_seq_pkg.sv
// Shared definitions for the acc32_seq accumulator: FSM state encoding and
// the saturation value used when the optional saturating mode is built in.
package acc32_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int          ADD_W     = 32;
    localparam logic [31:0] SAT_VALUE = 32'hFFFF_FFFF;

endpackage

// File: rtl/acc32_seq_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with a group-level
// carry chain. Purely combinational.
module acc32_seq_cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  blk_g;
    logic [7:0]  blk_p;
    logic [8:0]  blk_c;

    assign g = a & b;
    assign p = a ^ b;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_blk
            localparam int B = 4 * gi;
            logic [3:0] cl;

            assign blk_g[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                             | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign blk_p[gi] = p[B+3] & p[B+2] & p[B+1] & p[B];

            // In-group carries are flattened so each depends only on the group carry-in.
            assign cl[0] = blk_c[gi];
            assign cl[1] = g[B] | (p[B] & blk_c[gi]);
            assign cl[2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & blk_c[gi]);
            assign cl[3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                         | (p[B+2] & p[B+1] & p[B] & blk_c[gi]);
            assign s[B+3:B] = p[B+3:B] ^ cl;
        end
    endgenerate

    always_comb begin
        blk_c    = '0;
        blk_c[0] = ci;
        for (int k = 0; k < 8; k++) begin
            blk_c[k+1] = blk_g[k] | (blk_p[k] & blk_c[k]);
        end
    end

    assign co = blk_c[8];

endmodule

// File: rtl/acc32_seq.sv
// Multi-operand accumulator: sums a burst of words through the CLA adder and
// returns total plus sticky carry. Define ACC32_SEQ_SAT_EN to saturate on overflow.
module acc32_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    input  logic             out_ready,
    output logic             busy
);
    import acc32_seq_pkg::*;

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;

    logic [WIDTH-1:0] add_s;
    logic             add_co;
    logic [WIDTH-1:0] acc_next;

    acc32_seq_cla u_adder (
        .a  (acc_reg),
        .b  (in_data),
        .ci (1'b0),
        .s  (add_s),
        .co (add_co)
    );

`ifdef ACC32_SEQ_SAT_EN
    assign acc_next = add_co ? SAT_VALUE : add_s;
`else
    assign acc_next = add_s;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg   <= '0;
                        carry_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        if (num != '0) begin
                            cnt_reg      <= num;
                            state_reg    <= ACCUM;
                            in_ready_reg <= 1'b1;
                        end else begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready_reg) begin
                        acc_reg   <= acc_next;
                        carry_reg <= carry_reg | add_co;
                        cnt_reg   <= cnt_reg - CNT_W'(1);
                        if (cnt_reg == CNT_W'(1)) begin
                            state_reg     <= DONE;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // A start seen here is dropped; a new burst must begin from IDLE.
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_sum   = acc_reg;
    assign out_co    = carry_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_acc32_seq.sv
// Randomized scoreboard bench for acc32_seq: the driver queues the expected
// total of each burst, a monitor checks results at every output handshake.
module tb_acc32_seq;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_sum;
    logic             out_co;
    logic             out_ready;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [32:0] exp_q[$];
    logic [31:0] word_q[$];

    always #5 clk = ~clk;

    acc32_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num       (num),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_co    (out_co),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Reference: true integer total; carry flag is set iff the total reached 2^32.
    function automatic logic [32:0] model(input logic [31:0] w[$]);
        longint unsigned total;
        logic            co;
        logic [31:0]     s;
        total = 0;
        foreach (w[i]) total += 64'(w[i]);
        co = (total >> 32) != 0;
        s  = total[31:0];
`ifdef ACC32_SEQ_SAT_EN
        if (co) s = 32'hFFFF_FFFF;
`endif
        return {co, s};
    endfunction

    // Monitor: result checks at handshake, hold-stability under backpressure.
    logic        hold;
    logic [31:0] hold_sum;
    logic        hold_co;
    logic [32:0] e;
    initial hold = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                vectors++;
                if (out_valid !== 1'b1 || out_sum !== hold_sum || out_co !== hold_co) begin
                    miscompares++;
                    $display("FAIL hold_stable: got valid=%b sum=%h co=%b, need valid=1 sum=%h co=%b",
                             out_valid, out_sum, out_co, hold_sum, hold_co);
                end
            end
            if (out_valid) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL in_ready_in_done: got %b, need 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_result: got sum=%h co=%b, need no output", out_sum, out_co);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_co, out_sum} !== e) begin
                        miscompares++;
                        $display("FAIL result: got sum=%h co=%b, need sum=%h co=%b",
                                 out_sum, out_co, e[31:0], e[32]);
                    end else begin
                        $display("result sum=%h co=%b ok", out_sum, out_co);
                    end
                end
            end
            hold     = out_valid && !out_ready;
            hold_sum = out_sum;
            hold_co  = out_co;
        end
    end

    function automatic logic [31:0] rand_word();
        return ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 1000));
    endfunction

    // gap/bp < 0 selects a random 0..2 cycle stall / backpressure.
    task automatic run_burst(input int n, input int gap, input int bp, input bit start_in_hs);
        int g;
        int b;
        exp_q.push_back(model(word_q));
        start = 1'b1;
        num   = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            in_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = word_q[i];
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL in_ready_accum: got %b, need 1 (word %0d)", in_ready, i);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency: out_valid got %b, need 1 one cycle after last accept (n=%0d)", out_valid, n);
        end
        b = (bp < 0) ? int'($urandom_range(0, 2)) : bp;
        repeat (b) begin
            start = 1'($urandom_range(0, 1));
            num   = 8'd3;
            @(posedge clk); #1;
        end
        start     = start_in_hs;
        num       = 8'd3;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_hs: got busy=%b out_valid=%b, need 0 0", busy, out_valid);
        end
        $display("burst n=%0d issued", n);
        word_q.delete();
    endtask

    initial begin
        int n;
        int waitc;
        reset     = 1'b1;
        start     = 1'b0;
        num       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        @(negedge clk);
        vectors++;
        if ({busy, in_ready, out_valid, out_co, out_sum} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b in_ready=%b out_valid=%b co=%b sum=%h, need all 0",
                     busy, in_ready, out_valid, out_co, out_sum);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        word_q = '{32'd10, 32'd20, 32'd30};
        run_burst(3, 0, 0, 1'b0);

        word_q = '{32'hFFFF_FFFF, 32'h0000_0002};
        run_burst(2, 0, 0, 1'b0);

        word_q = '{32'd1234, 32'd5678};
        run_burst(2, 3, 5, 1'b1);

        run_burst(0, 0, 0, 1'b0);

        // Abort a burst mid-way; nothing may be reported for it.
        start = 1'b1;
        num   = 8'd4;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'd5;
        @(posedge clk); #1;
        in_data = 32'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort: got busy=%b in_ready=%b out_valid=%b, need 0 0 0",
                     busy, in_ready, out_valid);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        word_q = '{32'd7};
        run_burst(1, 0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            n = int'($urandom_range(0, 8));
            for (int i = 0; i < n; i++) word_q.push_back(rand_word());
            run_burst(n, -1, -1, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 255; i++) word_q.push_back(rand_word());
        run_burst(255, 0, 0, 1'b0);

        waitc = 0;
        while (exp_q.size() != 0 && waitc < 20) begin
            @(posedge clk);
            waitc++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_results: got %0d unreported bursts, need 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/acc32_seq.md
Name: acc32_seq

Overview:
- Clocked multi-operand accumulator placed directly downstream of the 32-bit carry-lookahead adder stage.
- Registers the adder's sum and feeds it back as operand A. A burst of N 32-bit words streamed in over a valid/ready handshake becomes a single 32-bit total.
- Also reports a sticky carry-out flag and returns the result over an output handshake.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported because the adder instance is fixed at 32 bits.
- CNT_W, 8, width of the operand-count field; maximum burst is 2^CNT_W-1 operands.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a burst; sampled only in IDLE
- num  input  CNT_W  operands in the burst; sampled with start
- in_valid  input  1  in_data is valid
- in_data  input  32  operand word
- in_ready  output  1  block accepts in_data this cycle
- out_valid  output  1  result available
- out_sum  output  32  accumulated sum
- out_co  output  1  sticky carry: 1 if any addition in the burst produced a carry-out
- out_ready  input  1  consumer takes the result
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, active-high): state=IDLE; acc=0; cnt=0; carry flag=0; all outputs 0.
- Asserting reset mid-burst aborts the burst immediately. No partial result is ever presented.
- State IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with num!=0: acc<=0, carry<=0, cnt<=num, go to ACCUM.
  - start=1 with num==0: acc<=0, carry<=0, go to DONE, so the result is 0 with co=0.
- State ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready: acc<=adder.s, where adder computes acc+in_data with ci=0; carry<=carry|adder.co; cnt<=cnt-1.
  - If the accept happens with cnt==1, go to DONE.
  - in_valid=0 stalls the burst indefinitely; state is held.
- State DONE:
  - out_valid=1; out_sum=acc; out_co=carry; in_ready=0.
  - On out_ready: go to IDLE.
  - out_sum and out_co are held stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises on the clock edge after the last operand is accepted, i.e. 1 cycle.
- Throughput: one operand per cycle in ACCUM.
- Minimum burst period is N+2 cycles (start cycle, N accepts, DONE handshake) when out_ready=1.
- start is ignored outside IDLE.
- start asserted in the same cycle the DONE handshake completes is ignored. A new burst needs start in IDLE.
- Arithmetic is unsigned, modulo 2^32, with no sign interpretation.
- The adder is purely combinational; acc is the only datapath register.

Optional Feature:
- Macro ACC32_SEQ_SAT_EN.
- Defined: any accept whose adder.co=1 loads acc<=32'hFFFF_FFFF instead of adder.s. acc stays saturated for the rest of the burst. out_co behaves identically.
- Undefined: acc wraps modulo 2^32.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and the saturation constant 32'hFFFF_FFFF.
- Sub-module: the existing 32-bit carry-lookahead adder module, instantiated once with ci tied to 0. No other sub-modules.

Test Plan:
- Reset mid-burst: start, num=4, accept 2 words, then pulse reset -> next cycle state=IDLE, out_valid=0, in_ready=0, busy=0; a new burst num=1 with 7 -> out_sum=7.
- Basic burst: start, num=3; words 10, 20, 30 with in_valid held high -> out_valid one cycle after the third accept, out_sum=60, out_co=0, busy deasserts after out_ready.
- Carry/wrap: num=2; words 0xFFFF_FFFF, 0x0000_0002 -> out_sum=0x0000_0001, out_co=1. With ACC32_SEQ_SAT_EN: out_sum=0xFFFF_FFFF, out_co=1.
- Stalls and backpressure: num=2 with in_valid gaps of 3 cycles -> acc unchanged during gaps; out_ready held low 5 cycles -> out_sum stable, in_ready=0, start pulses ignored.
- Zero-length: start, num=0 -> DONE next cycle, out_sum=0, out_co=0, no operands accepted.
